ram_ctrl_md: RTL and testbench

- Parametrised single-port synchronous data RAM with a controller, successor to the fixed 256x16 data-memory block.
- Adds the following over a bare RAM:
  - configurable width and depth;
  - req/ready request handshake;
  - configurable read-latency pipeline with a valid strobe;
  - hardware clear of all words after reset.
- Sits between the CPU load/store stage and the storage array.

---
 rtl/ram_pkg.sv | 17 +
 rtl/ram_core_md.sv | 35 +++
 rtl/ram_ctrl_md.sv | 152 +++++++++++++++
 tb/tb_ram_ctrl_md.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and constants for the ram_ctrl_md data-memory controller.
package ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam int RD_LAT_MAX = 3;

    function automatic bit params_legal(input int dw, input int depth, input int rd_lat);
        return (dw >= 8) && (dw <= 64) && ((dw % 8) == 0) &&
               (depth >= 2) && (depth <= 4096) &&
               (rd_lat >= 1) && (rd_lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/ram_core_md.sv
// Single-port storage array: synchronous byte-lane write, registered read.
module ram_core_md #(
    parameter int DW    = 16,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic            rd_en_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic [DW/8-1:0] be_i,
    output logic [DW-1:0]   rdata_o
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    // No reset on the array or its output register so the tools can map both into block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < DW/8; i++) begin
                if (be_i[i]) begin
                    mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
        if (rd_en_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_ctrl_md.sv
// Data-memory controller: post-reset clear, req/ready handshake, range check, read-latency pipeline.
// Optional byte write enables when RAM_BYTE_WE_EN is defined.
module ram_ctrl_md
    import ram_pkg::*;
#(
    parameter int DW     = 16,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH),
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   D_in,
`ifdef RAM_BYTE_WE_EN
    input  logic [DW/8-1:0] be,
`endif
    output logic            ready,
    output logic            busy,
    output logic [DW-1:0]   D_out,
    output logic            D_valid
);

    if (!params_legal(DW, DEPTH, RD_LAT) || (AW != $clog2(DEPTH))) begin : g_bad_params
        $error("ram_ctrl_md: illegal parameter combination");
    end

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            accept, in_range, rd_acc;
    logic            core_we, core_rd_en;
    logic [AW-1:0]   core_addr;
    logic [DW-1:0]   core_wdata, core_rdata;
    logic [DW/8-1:0] core_be, be_eff;
    logic [RD_LAT-1:0] vld_q;
    logic            zero_q;
    logic [DW-1:0]   first_view;

`ifdef RAM_BYTE_WE_EN
    assign be_eff = be;
`else
    assign be_eff = '1;
`endif

    assign ready    = (state_q == IDLE);
    assign busy     = (state_q == CLEAR);
    assign accept   = req && ready;
    assign in_range = ({1'b0, addr} < DEPTH_EXT);
    assign rd_acc   = accept && !we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // The clear owns the array port; requests cannot arrive then because ready is low.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        core_we    = accept && we && in_range;
        core_rd_en = rd_acc && in_range;
        core_addr  = addr;
        core_wdata = D_in;
        core_be    = be_eff;
        case (state_q)
            CLEAR: begin
                core_we    = 1'b1;
                core_rd_en = 1'b0;
                core_addr  = clr_cnt_q;
                core_wdata = '0;
                core_be    = '1;
                clr_cnt_d  = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end
            end
            IDLE:    ;
            default: state_d = CLEAR;
        endcase
    end

    ram_core_md #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_core (
        .clk     (clk),
        .we_i    (core_we),
        .rd_en_i (core_rd_en),
        .addr_i  (core_addr),
        .wdata_i (core_wdata),
        .be_i    (core_be),
        .rdata_o (core_rdata)
    );

    // zero_q masks the unreset core register after reset and for out-of-range reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            vld_q[0] <= rd_acc;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            if (rd_acc) begin
                zero_q <= !in_range;
            end
        end
    end

    assign first_view = zero_q ? '0 : core_rdata;
    assign D_valid    = vld_q[RD_LAT-1];

    if (RD_LAT == 1) begin : g_lat1
        assign D_out = first_view;
    end else begin : g_latn
        logic [DW-1:0] pipe_q [RD_LAT-1];

        // Stages load only when carrying a read, so D_out holds between reads.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < RD_LAT-1; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                if (vld_q[0]) begin
                    pipe_q[0] <= first_view;
                end
                for (int i = 1; i < RD_LAT-1; i++) begin
                    if (vld_q[i]) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end
        end

        assign D_out = pipe_q[RD_LAT-2];
    end

endmodule

// File: tb/tb_ram_ctrl_md.sv
// Randomised bench: three controllers (DEPTH/RD_LAT = 256/1, 200/2, 256/3) share one stimulus
// and are checked every cycle against a time-indexed behavioural model.
module tb_ram_ctrl_md;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        req  = 1'b0;
    logic        we   = 1'b0;
    logic [7:0]  addr = '0;
    logic [15:0] din  = '0;
    logic [1:0]  be   = 2'b11;

    logic        rdy  [3];
    logic        bsy  [3];
    logic        dv   [3];
    logic [15:0] dout [3];

    always #5 clk = ~clk;

    function automatic int dep_of(input int k);
        return (k == 1) ? 200 : 256;
    endfunction

    function automatic int lat_of(input int k);
        return k + 1;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        ram_ctrl_md #(
            .DW     (16),
            .DEPTH  (dep_of(gi)),
            .RD_LAT (lat_of(gi))
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .req     (req),
            .we      (we),
            .addr    (addr),
            .D_in    (din),
`ifdef RAM_BYTE_WE_EN
            .be      (be),
`endif
            .ready   (rdy[gi]),
            .busy    (bsy[gi]),
            .D_out   (dout[gi]),
            .D_valid (dv[gi])
        );
    end

    int checks = 0;
    int errors = 0;

    // Model: rel counts clock edges since reset release; reads are filed by the edge count
    // at which their data must be visible.
    logic [15:0] mem   [3][256];
    bit          due_v [3][8];
    logic [15:0] due_d [3][8];
    logic [15:0] hold  [3];
    int          rel   = 0;
    bit          armed = 1'b0;

    logic        obs_v [3];
    logic        obs_r [3];
    logic [15:0] obs_d [3];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            bit ev;
            int idx;
            idx = rel % 8;
            ev  = due_v[k][idx];
            if (ev) begin
                hold[k]       = due_d[k][idx];
                due_v[k][idx] = 1'b0;
            end
            if (armed) begin
                chk("ready",   k, 32'(rdy[k]), 32'(rel >= dep_of(k)));
                chk("busy",    k, 32'(bsy[k]), 32'(rel <  dep_of(k)));
                chk("d_valid", k, 32'(dv[k]),  32'(ev));
                chk("d_out",   k, 32'(dout[k]), 32'(hold[k]));
            end
            obs_v[k] = dv[k];
            obs_r[k] = rdy[k];
            obs_d[k] = dout[k];
        end
    endtask

    task automatic model_reset();
        rel = 0;
        for (int k = 0; k < 3; k++) begin
            hold[k] = '0;
            for (int j = 0; j < 8; j++) due_v[k][j] = 1'b0;
        end
    endtask

    task automatic advance();
        logic [1:0] be_eff;
`ifdef RAM_BYTE_WE_EN
        be_eff = be;
`else
        be_eff = 2'b11;
`endif
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (req && (rel >= dep_of(k))) begin
                    if (we) begin
                        if (int'(addr) < dep_of(k)) begin
                            for (int l = 0; l < 2; l++)
                                if (be_eff[l]) mem[k][addr][l*8 +: 8] = din[l*8 +: 8];
                        end
                    end else begin
                        int due;
                        due = rel + lat_of(k);
                        due_v[k][due % 8] = 1'b1;
                        due_d[k][due % 8] = (int'(addr) < dep_of(k)) ? mem[k][addr] : 16'h0000;
                    end
                end
            end
            rel++;
            for (int k = 0; k < 3; k++) begin
                if (rel == dep_of(k)) begin
                    for (int a = 0; a < 256; a++) mem[k][a] = '0;
                end
            end
        end
    endtask

    task automatic tick(input logic r, input logic rq, input logic w, input logic [7:0] a,
                        input logic [15:0] d, input logic [1:0] b);
        @(negedge clk);
        check_all();
        rst  = r;
        req  = rq;
        we   = w;
        addr = a;
        din  = d;
        be   = b;
        advance();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b11);
    endtask

    initial begin
        int          first [3];
        int          lat_seen [3];
        logic [15:0] val [3];
        logic [15:0] got [4];
        int          pos [4];
        int          n;
        int          nv;

        tick(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b11);
        armed = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b11);
        tick(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b11);

        // Clear length after release
        tick(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b11);
        for (int k = 0; k < 3; k++) first[k] = -1;
        for (int i = 1; i <= 300; i++) begin
            idle(1);
            for (int k = 0; k < 3; k++) if (obs_r[k] && first[k] < 0) first[k] = i;
        end
        for (int k = 0; k < 3; k++) chk("clear_cycles", k, 32'(first[k]), 32'(dep_of(k)));

        tick(1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 2'b11);
        tick(1'b0, 1'b1, 1'b0, 8'h7F, 16'h0000, 2'b11);
        tick(1'b0, 1'b1, 1'b0, 8'hFF, 16'h0000, 2'b11);
        idle(4);

        // Write-then-read latency
        tick(1'b0, 1'b1, 1'b1, 8'h12, 16'hBEEF, 2'b11);
        tick(1'b0, 1'b1, 1'b0, 8'h12, 16'h0000, 2'b11);
        for (int k = 0; k < 3; k++) begin lat_seen[k] = -1; val[k] = '0; end
        for (int j = 1; j <= 6; j++) begin
            idle(1);
            for (int k = 0; k < 3; k++)
                if (obs_v[k] && lat_seen[k] < 0) begin lat_seen[k] = j; val[k] = obs_d[k]; end
        end
        for (int k = 0; k < 3; k++) begin
            chk("beef_latency", k, 32'(lat_seen[k]), 32'(lat_of(k)));
            chk("beef_data",    k, 32'(val[k]),      32'h0000BEEF);
        end

        // Back-to-back reads in order
        tick(1'b0, 1'b1, 1'b1, 8'h01, 16'h1111, 2'b11);
        tick(1'b0, 1'b1, 1'b1, 8'h02, 16'h2222, 2'b11);
        tick(1'b0, 1'b1, 1'b1, 8'h03, 16'h3333, 2'b11);
        n = 0;
        for (int j = 0; j < 10; j++) begin
            if (j < 3) tick(1'b0, 1'b1, 1'b0, 8'(j + 1), 16'h0000, 2'b11);
            else       idle(1);
            if (obs_v[2] && n < 4) begin got[n] = obs_d[2]; pos[n] = j; n++; end
        end
        chk("order_count", 2, 32'(n), 32'd3);
        chk("order_0", 2, 32'(got[0]), 32'h00001111);
        chk("order_1", 2, 32'(got[1]), 32'h00002222);
        chk("order_2", 2, 32'(got[2]), 32'h00003333);
        chk("order_gap", 2, 32'(pos[2] - pos[0]), 32'd2);

        // Out-of-range for DEPTH=200
        tick(1'b0, 1'b1, 1'b1, 8'd210, 16'hAAAA, 2'b11);
        tick(1'b0, 1'b1, 1'b0, 8'd210, 16'h0000, 2'b11);
        for (int k = 0; k < 3; k++) val[k] = 16'h5555;
        for (int j = 0; j < 5; j++) begin
            idle(1);
            for (int k = 0; k < 3; k++) if (obs_v[k]) val[k] = obs_d[k];
        end
        chk("oor_read", 1, 32'(val[1]), 32'h00000000);
        chk("inrange_read", 0, 32'(val[0]), 32'h0000AAAA);

        // Byte lanes
        tick(1'b0, 1'b1, 1'b1, 8'h40, 16'h1234, 2'b11);
        tick(1'b0, 1'b1, 1'b1, 8'h40, 16'hABCD, 2'b10);
        tick(1'b0, 1'b1, 1'b0, 8'h40, 16'h0000, 2'b11);
        idle(4);
`ifdef RAM_BYTE_WE_EN
        chk("byte_lane", 0, 32'(obs_d[0]), 32'h0000AB34);
`else
        chk("full_word", 0, 32'(obs_d[0]), 32'h0000ABCD);
`endif

        for (int i = 0; i < 600; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            tick(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
                 16'($urandom), 2'($urandom_range(0, 3)));
        end
        idle(4);

        // Reset two edges after a read accept drops the RD_LAT=3 result
        tick(1'b0, 1'b1, 1'b0, 8'h12, 16'h0000, 2'b11);
        idle(1);
        tick(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b11);
        tick(1'b1, 1'b1, 1'b0, 8'h05, 16'h0000, 2'b11);
        nv = 0;
        if (obs_v[2]) nv++;
        tick(1'b0, 1'b1, 1'b0, 8'h05, 16'h0000, 2'b11);
        if (obs_v[2]) nv++;
        for (int k = 0; k < 3; k++) first[k] = -1;
        for (int i = 1; i <= 300; i++) begin
            tick(1'b0, 1'b1, 1'b0, 8'h05, 16'h0000, 2'b11);
            if (obs_v[2] && first[2] < 0) nv++;
            for (int k = 0; k < 3; k++) if (obs_r[k] && first[k] < 0) first[k] = i;
        end
        chk("no_valid_after_rst", 2, 32'(nv), 32'd0);
        for (int k = 0; k < 3; k++) chk("reclear_cycles", k, 32'(first[k]), 32'(dep_of(k)));
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by t=%0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
